// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared pipeline types and defaults for the MEM/WB stage
package mem_wb_stage_pkg;
    typedef enum logic {IDLE, WAIT} stateT;
    localparam int MEM_TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: request/acknowledge bus between the MEM stage and data memory
interface mem_wb_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: WB output registers; valid pulses per completion, fields hold in between
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        regWriteIn,
    input  logic [4:0]  destIn,
    input  logic [31:0] dataIn,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data
);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
        end else begin
            wb_valid <= load;
            if (load) begin
                wb_reg_write <= regWriteIn;
                wb_dest      <= destIn;
                wb_data      <= dataIn;
            end
        end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB stage issuing one memory request at a time with a bounded wait
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [31:0]    in_pc_branch,
    input  logic           in_zf,
    input  logic [31:0]    in_alu_result,
    input  logic [31:0]    in_store_data,
    input  logic [4:0]     in_dest_reg,
    input  logic           in_branch,
    input  logic           in_mem_read,
    input  logic           in_mem_write,
    input  logic           in_reg_write,
    input  logic           in_mem_to_reg,
    input  logic           in_jump,
    input  logic [31:0]    in_jump_target,
    mem_wb_stage_if.master mem,
    output logic           stall,
    output logic           pc_redirect,
    output logic [31:0]    pc_target,
    output logic           wb_valid,
    output logic           wb_reg_write,
    output logic [4:0]     wb_dest,
    output logic [31:0]    wb_data,
    output logic           err_misalign,
    output logic           err_timeout
);
    stateT       state;
    logic [7:0]  cnt;
    logic [4:0]  latDest;
    logic        latRegWrite, latMemToReg;
    logic        isMemop, accept, idleDone, ackDone, toDone, timeoutHit;
    logic        wbLoad, wbRegWriteNext;
    logic [4:0]  wbDestNext;
    logic [31:0] wbDataNext;

    assign isMemop    = in_valid & (in_mem_read | in_mem_write);
    assign accept     = state == IDLE & isMemop & in_alu_result[1:0] == 2'b00;
    assign idleDone   = state == IDLE & in_valid & !accept;
    assign timeoutHit = cnt == 8'(MEM_TIMEOUT);
    assign ackDone    = state == WAIT & mem.mem_ack;
    assign toDone     = state == WAIT & !mem.mem_ack & timeoutHit;
    assign stall      = !rst & (accept | (state == WAIT & !mem.mem_ack & !timeoutHit));

    // Misaligned memops and timeouts complete without a register write
    always_comb begin
        wbLoad         = idleDone | ackDone | toDone;
        wbRegWriteNext = ackDone ? latRegWrite & !mem.mem_we : idleDone & !isMemop & in_reg_write;
        wbDestNext     = state == WAIT ? latDest : in_dest_reg;
        wbDataNext     = ackDone & latMemToReg ? mem.mem_rdata : state == WAIT ? mem.mem_addr : in_alu_result;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            latDest       <= '0;
            latRegWrite   <= 1'b0;
            latMemToReg   <= 1'b0;
            pc_redirect   <= 1'b0;
            pc_target     <= '0;
            err_misalign  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            pc_redirect <= state == IDLE & in_valid & ((in_branch & in_zf) | in_jump);
            if (state == IDLE & in_valid) pc_target <= in_jump ? in_jump_target : in_pc_branch;
            if (accept) begin
                state         <= WAIT;
                cnt           <= '0;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= in_mem_write;
                mem.mem_addr  <= in_alu_result;
                mem.mem_wdata <= in_store_data;
                latDest       <= in_dest_reg;
                latRegWrite   <= in_reg_write;
                latMemToReg   <= in_mem_to_reg;
            end else if (ackDone | toDone) begin
                state       <= IDLE;
                mem.mem_req <= 1'b0;
            end else if (state == WAIT) cnt <= cnt + 8'd1;
            if (idleDone & isMemop) err_misalign <= 1'b1;
            if (toDone) err_timeout <= 1'b1;
        end

    mem_wb_reg wbReg (
        .clk          (clk),
        .rst          (rst),
        .load         (wbLoad),
        .regWriteIn   (wbRegWriteNext),
        .destIn       (wbDestNext),
        .dataIn       (wbDataNext),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data)
    );
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scoreboard bench for mem_wb_stage with MEM_TIMEOUT=4
module tb_mem_wb_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid, in_zf, in_branch, in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_jump;
    logic [31:0] in_pc_branch, in_alu_result, in_store_data, in_jump_target;
    logic [4:0]  in_dest_reg;
    logic        stall, pc_redirect, wb_valid, wb_reg_write, err_misalign, err_timeout;
    logic [31:0] pc_target, wb_data;
    logic [4:0]  wb_dest;
    int          checks = 0, errors = 0, stallHigh, n;

    typedef struct packed {logic regWrite; logic [4:0] dest; logic [31:0] data;} wbT;
    wbT sbq[$];

    mem_wb_stage_if memIf ();

    mem_wb_stage #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc_branch(in_pc_branch), .in_zf(in_zf),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_dest_reg(in_dest_reg),
        .in_branch(in_branch), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_jump(in_jump),
        .in_jump_target(in_jump_target), .mem(memIf), .stall(stall), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
        .wb_data(wb_data), .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog observed=no_finish required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        {in_valid, in_zf, in_branch, in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_jump} = '0;
        {in_pc_branch, in_alu_result, in_store_data, in_jump_target} = '0;
        in_dest_reg = '0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] dest, input logic rw, input logic m2r);
        clearIn();
        in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_alu_result = alu;
        in_store_data = sd; in_dest_reg = dest; in_reg_write = rw; in_mem_to_reg = m2r;
    endtask

    task automatic checkWb(input string tag);
        wbT e;
        chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
        checks++;
        assert (sbq.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_rw"}, 32'(wb_reg_write), 32'(e.regWrite));
            chk({tag, "_dest"}, 32'(wb_dest), 32'(e.dest));
            chk({tag, "_data"}, wb_data, e.data);
        end
    endtask

    initial begin
        clearIn();
        memIf.mem_ack = 1'b0;
        memIf.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        drive(1, 0, 32'h100, 0, 5'd1, 1, 1);
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(memIf.mem_req), 0);
        chk("rst_wbv", 32'(wb_valid), 0);
        chk("rst_pct", pc_target, 0);
        chk("rst_err", 32'({err_misalign, err_timeout}), 0);
        clearIn();
        rst = 1'b0;
        cyc();

        drive(0, 0, 32'h10, 0, 5'd5, 1, 0);
        sbq.push_back('{1'b1, 5'd5, 32'h10});
        #1 chk("alu_stall", 32'(stall), 0);
        cyc();
        clearIn();
        checkWb("alu");
        chk("alu_stall2", 32'(stall), 0);
        cyc();
        chk("alu_vdrop", 32'(wb_valid), 0);

        drive(1, 0, 32'h100, 0, 5'd7, 1, 1);
        sbq.push_back('{1'b1, 5'd7, 32'hDEADBEEF});
        stallHigh = 0;
        #1 if (stall) stallHigh++;
        cyc();
        clearIn();
        chk("ld_req", 32'(memIf.mem_req), 1);
        chk("ld_we", 32'(memIf.mem_we), 0);
        chk("ld_addr", memIf.mem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            if (stall) stallHigh++;
            cyc();
        end
        memIf.mem_ack = 1'b1;
        memIf.mem_rdata = 32'hDEADBEEF;
        #1 chk("ld_ackstall", 32'(stall), 0);
        chk("ld_stallcnt", 32'(stallHigh), 4);
        cyc();
        memIf.mem_ack = 1'b0;
        checkWb("ld");
        chk("ld_reqdrop", 32'(memIf.mem_req), 0);

        drive(0, 1, 32'h204, 32'h1234, 5'd3, 1, 0);
        sbq.push_back('{1'b0, 5'd3, 32'h204});
        #1 chk("st_stall", 32'(stall), 1);
        cyc();
        clearIn();
        in_store_data = 32'hFFFF;
        chk("st_we", 32'(memIf.mem_we), 1);
        chk("st_wdata0", memIf.mem_wdata, 32'h1234);
        cyc();
        chk("st_wdata1", memIf.mem_wdata, 32'h1234);
        chk("st_addr1", memIf.mem_addr, 32'h204);
        memIf.mem_ack = 1'b1;
        cyc();
        memIf.mem_ack = 1'b0;
        checkWb("st");

        drive(1, 0, 32'h102, 0, 5'd9, 1, 1);
        sbq.push_back('{1'b0, 5'd9, 32'h102});
        #1 chk("mis_stall", 32'(stall), 0);
        cyc();
        clearIn();
        chk("mis_req", 32'(memIf.mem_req), 0);
        chk("mis_err", 32'(err_misalign), 1);
        checkWb("mis");
        memIf.mem_ack = 1'b1;
        cyc();
        memIf.mem_ack = 1'b0;
        chk("idleack_wbv", 32'(wb_valid), 0);
        chk("idleack_req", 32'(memIf.mem_req), 0);

        drive(1, 0, 32'h300, 0, 5'd4, 1, 1);
        sbq.push_back('{1'b0, 5'd4, 32'h300});
        stallHigh = 0;
        n = 0;
        #1 if (stall) stallHigh++;
        cyc();
        clearIn();
        while (!wb_valid && n < 12) begin
            if (stall) stallHigh++;
            cyc();
            n++;
        end
        chk("to_bound", 32'(n < 12), 1);
        chk("to_stallcnt", 32'(stallHigh), 5);
        checkWb("to");
        chk("to_err", 32'(err_timeout), 1);
        chk("to_reqdrop", 32'(memIf.mem_req), 0);
        chk("to_missticky", 32'(err_misalign), 1);

        drive(1, 0, 32'h108, 0, 5'd6, 1, 1);
        sbq.push_back('{1'b1, 5'd6, 32'hCAFEF00D});
        cyc();
        clearIn();
        repeat (4) cyc();
        memIf.mem_ack = 1'b1;
        memIf.mem_rdata = 32'hCAFEF00D;
        #1 chk("race_stall", 32'(stall), 0);
        cyc();
        memIf.mem_ack = 1'b0;
        checkWb("race");

        clearIn();
        in_valid = 1'b1; in_branch = 1'b1; in_zf = 1'b1; in_jump = 1'b1;
        in_jump_target = 32'h400; in_pc_branch = 32'h800;
        sbq.push_back('{1'b0, 5'd0, 32'h0});
        cyc();
        clearIn();
        chk("jmp_redir", 32'(pc_redirect), 1);
        chk("jmp_tgt", pc_target, 32'h400);
        checkWb("jmp");
        cyc();
        chk("jmp_pulse", 32'(pc_redirect), 0);
        chk("jmp_hold", pc_target, 32'h400);
        in_valid = 1'b1; in_branch = 1'b1; in_zf = 1'b1;
        in_jump_target = 32'h400; in_pc_branch = 32'h800;
        cyc();
        clearIn();
        chk("br_redir", 32'(pc_redirect), 1);
        chk("br_tgt", pc_target, 32'h800);
        in_valid = 1'b1; in_branch = 1'b1; in_pc_branch = 32'h900;
        cyc();
        clearIn();
        chk("brnt_redir", 32'(pc_redirect), 0);
        sbq.delete();

        drive(1, 0, 32'h500, 0, 5'd8, 1, 1);
        cyc();
        clearIn();
        chk("rw_req", 32'(memIf.mem_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("rw_req0", 32'(memIf.mem_req), 0);
        chk("rw_addr0", memIf.mem_addr, 0);
        chk("rw_stall0", 32'(stall), 0);
        chk("rw_wb0", {wb_data[30:0], wb_valid}, 0);
        chk("rw_pc0", pc_target, 0);
        chk("rw_err0", 32'({err_misalign, err_timeout, pc_redirect}), 0);
        cyc();
        chk("rw_nowb", 32'(wb_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
